// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I datapath: steps FETCH/DECODE/EXEC/MEM/WB
// and drives datapath enables, operand/writeback muxes and a shared req/ready memory port.
module multicycle_control #(
  parameter bit RESET_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_LOAD, C_STORE, C_OP_IMM, C_OP, C_LUI, C_AUIPC,
    C_BRANCH, C_JAL, C_JALR, C_SYSTEM, C_ILLEGAL
  } cls_e;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_e state_q, state_d;
  cls_e   cls_q, cls_dec;

  always_comb begin
    case (opcode)
      OPC_LOAD:   cls_dec = C_LOAD;
      OPC_STORE:  cls_dec = C_STORE;
      OPC_OP_IMM: cls_dec = C_OP_IMM;
      OPC_OP:     cls_dec = C_OP;
      OPC_LUI:    cls_dec = C_LUI;
      OPC_AUIPC:  cls_dec = C_AUIPC;
      OPC_BRANCH: cls_dec = C_BRANCH;
      OPC_JAL:    cls_dec = C_JAL;
      OPC_JALR:   cls_dec = C_JALR;
      OPC_SYSTEM: cls_dec = (funct3 == 3'b000) ? C_SYSTEM : C_ILLEGAL;
      default:    cls_dec = C_ILLEGAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_HALT ? S_HALT : S_FETCH;
    else        state_q <= state_d;
  end

  // Class is captured once in DECODE so later IR/opcode changes cannot disturb EXEC/MEM/WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cls_q <= C_ILLEGAL;
    else if (state_q == S_DECODE)   cls_q <= cls_dec;
  end

  // NOTE: every output and state_d gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = A_RS1;
    alu_src_b    = B_RS2;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;

    // Outputs are forced low for the whole reset window, including a fetch caught mid-wait.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          case (cls_dec)
            C_SYSTEM:  state_d = S_HALT;
            C_ILLEGAL: state_d = S_TRAP;
            default:   state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            C_OP: state_d = S_WB;
            C_OP_IMM: begin
              alu_src_b = B_IMM;
              state_d   = S_WB;
            end
            C_LOAD, C_STORE: begin
              alu_src_b = B_IMM;
              state_d   = S_MEM;
            end
            C_LUI: begin
              alu_src_a = A_ZERO;
              alu_src_b = B_IMM;
              state_d   = S_WB;
            end
            C_AUIPC: begin
              alu_src_a = A_PC;
              alu_src_b = B_IMM;
              state_d   = S_WB;
            end
            C_BRANCH: begin
              alu_src_a = A_PC;
              alu_src_b = B_IMM;
              pc_we     = 1'b1;
              pc_src    = branch_taken;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
            C_JAL, C_JALR: begin
              alu_src_a = (cls_q == C_JAL) ? A_PC : A_RS1;
              alu_src_b = B_IMM;
              pc_we     = 1'b1;
              pc_src    = 1'b1;
              reg_we    = 1'b1;
              wb_sel    = WB_PC4;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
            default: state_d = S_TRAP;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls_q == C_STORE);
          if (mem_ready) begin
            if (cls_q == C_STORE) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_we  = 1'b1;
          wb_sel  = (cls_q == C_LOAD) ? WB_MEM : WB_ALU;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT:  halted  = 1'b1;
        S_TRAP:  illegal = 1'b1;
        default: state_d = S_TRAP;
      endcase
    end
  end

endmodule
